tl_sram_slave: RTL and testbench
================================

Name: tl_sram_slave

Overview:
- Single-port on-chip SRAM target sitting directly downstream of the core crossbar; one instance per crossbar target port (Dcache side, Icache side).
- Accepts TileLink-UL A-channel requests (Get, PutFullData, PutPartialData) and returns one D-channel response per request (AccessAck / AccessAckData).
- One request outstanding at a time; out-of-range, misaligned or unsupported requests are answered with denied.

Parameters:
ADDR_BASE, 32'h80000000, byte address of word 0
DEPTH_WORDS, 4096, number of 32-bit words (default 16 KiB, covers 0x80000000-0x80003fff)
AW, 12, word-index width, clog2(DEPTH_WORDS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
a_valid  in  1  A-channel request valid
a_ready  out  1  A-channel request accepted
a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
a_param  in  3  ignored
a_size  in  4  log2 bytes
a_source  in  5  request ID
a_address  in  32  byte address
a_mask  in  4  byte lanes
a_data  in  32  write data
a_corrupt  in  1  write data corrupt; write suppressed when set
d_valid  out  1  response valid
d_ready  in  1  response accepted
d_opcode  out  3  0=AccessAck, 1=AccessAckData
d_param  out  2  always 0
d_size  out  4  echo of a_size
d_source  out  5  echo of a_source
d_sink  out  2  always 0
d_denied  out  1  request rejected
d_corrupt  out  1  data not valid
d_data  out  32  read data

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - a_ready=0 while rst is high, then 1 from the first cycle after rst falls.
  - d_valid=0 and all d_* outputs 0.
  - SRAM contents are not cleared by reset.
- FSM states: IDLE, RESP (plus BURST under the option).
  - a_ready = (state==IDLE) && !rst.
- Accept: a_valid && a_ready in cycle T. The block captures opcode, size, source and address, then moves to RESP at T+1.
  - d_valid is high at T+1. Latency is exactly 1 cycle for all request types.
- Legality check (evaluated at accept):
  - Address must satisfy ADDR_BASE <= a_address < ADDR_BASE + 4*DEPTH_WORDS.
  - Opcode must be in {0,1,4}.
  - a_size <= 2.
  - a_address must be aligned to 2^a_size.
  - Any failure sets denied: no SRAM access; the response carries d_denied=1.
- Word index = (a_address - ADDR_BASE) >> 2, truncated to AW bits.
- Get:
  - SRAM read is issued at T; data is presented at T+1 as d_opcode=1.
  - Full 32-bit word is returned regardless of size.
  - Denied Get returns d_opcode=1, d_data=0, d_denied=1, d_corrupt=1.
- Put:
  - Byte lanes with a_mask[i]=1 are written at T; PutFullData also uses the mask.
  - Response is d_opcode=0, d_data=0, d_corrupt=0.
  - a_corrupt=1 suppresses the write but still returns AccessAck.
  - Denied Put returns d_opcode=0, d_denied=1, d_corrupt=0.
- RESP state:
  - All d_* outputs stay stable while d_valid && !d_ready, for any number of stall cycles.
  - On d_valid && d_ready the FSM returns to IDLE; a_ready is 1 the next cycle.
  - Peak throughput is one request per 2 cycles.
- No combinational path from d_ready to a_ready, and none from a_valid to d_valid.
- Read after write to the same word in back-to-back requests returns the new data.
- rst asserted mid-operation: the pending response is dropped (d_valid=0 next cycle) and the FSM goes to IDLE. A write already committed at accept remains.

Optional Feature:
- Macro: TL_SRAM_BURST_EN.
- Defined:
  - Get with a_size=3 (2 beats) or a_size=4 (4 beats) is legal when the address is aligned to 2^a_size.
  - FSM enters BURST; a beat counter advances the word index by 1 on each d_valid && d_ready.
  - Each beat is a separate d_valid with d_opcode=1 and d_size=a_size.
  - The FSM returns to IDLE after the last beat handshake.
  - Puts with size>2 are still denied.
- Not defined: any a_size>2 is denied, with 1 response beat.

Test Plan:
- Reset, then PutFullData addr 0x80000010, mask 4'hF, data 0xDEADBEEF at T -> d_valid at T+1, d_opcode=0, d_denied=0. Get addr 0x80000010 -> d_opcode=1, d_data=0xDEADBEEF, d_source echoed.
- PutPartialData addr 0x80000010, mask 4'b0010, data 0x0000AA00, then Get -> d_data=0xDEADAAEF.
- Get addr 0x80004000 (out of range) -> d_denied=1, d_corrupt=1, d_data=0. Get addr 0x80000002, size 2 -> d_denied=1.
- Stall: Get with d_ready=0 for 5 cycles -> d_valid and d_data constant; a_ready=0 throughout; a_ready=1 the cycle after the handshake.
- rst pulsed while in RESP -> d_valid=0 next cycle. Later Get of the previously written word returns the written data.
- TL_SRAM_BURST_EN: Get size 4 addr 0x80000020 after writing 1,2,3,4 to words 8..11 -> four beats with d_data 1,2,3,4. Without the macro -> a single denied beat.

Source files
------------

// File: rtl/tl_sram_slave.sv
// TileLink-UL single-port SRAM target: one outstanding request, 1-cycle response latency.
// Define TL_SRAM_BURST_EN to accept multi-beat Gets (a_size 3 or 4).
module tl_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h80000000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [3:0]  a_size,
    input  logic [4:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [3:0]  d_size,
    output logic [4:0]  d_source,
    output logic [1:0]  d_sink,
    output logic        d_denied,
    output logic        d_corrupt,
    output logic [31:0] d_data
);

`ifdef TL_SRAM_BURST_EN
    typedef enum logic [1:0] {IDLE, RESP, BURST} stateT;
`else
    typedef enum logic [0:0] {IDLE, RESP} stateT;
`endif

    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    stateT       state, stateNext;
    logic [31:0] mem [DEPTH_WORDS];
    logic [32:0] offset;
    logic [31:0] alignMask;
    logic [AW-1:0] wordIdx;
    logic        accept, dHs, isGet, isPut, inRange, aligned, sizeOk, legal;
    logic        burstReq, goBurst;
    logic        unusedParam;

    assign unusedParam = ^a_param;

    assign accept  = a_valid && a_ready;
    assign dHs     = d_valid && d_ready;
    assign a_ready = (state == IDLE) && !rst;
    assign d_valid = (state != IDLE);
    assign d_param = '0;
    assign d_sink  = '0;

    // Addresses below the base wrap to large 33-bit offsets and fail the span test.
    assign offset    = {1'b0, a_address} - {1'b0, ADDR_BASE};
    assign inRange   = offset < SPAN;
    assign alignMask = (32'd1 << a_size) - 32'd1;
    assign aligned   = (a_address & alignMask) == '0;
    assign wordIdx   = offset[AW+1:2];
    assign isGet     = (a_opcode == 3'd4);
    assign isPut     = (a_opcode == 3'd0) || (a_opcode == 3'd1);

`ifdef TL_SRAM_BURST_EN
    assign burstReq = isGet && ((a_size == 4'd3) || (a_size == 4'd4));
`else
    assign burstReq = 1'b0;
`endif
    assign sizeOk  = (a_size <= 4'd2) || burstReq;
    assign legal   = (isGet || isPut) && inRange && aligned && sizeOk;
    assign goBurst = burstReq && legal;

`ifdef TL_SRAM_BURST_EN
    logic [AW-1:0] curIdx, nextIdx;
    logic [1:0]    beatsLeft;
    assign nextIdx = curIdx + AW'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef TL_SRAM_BURST_EN
                    stateNext = goBurst ? BURST : RESP;
`else
                    stateNext = RESP;
`endif
                end
            end
            RESP: if (dHs) stateNext = IDLE;
`ifdef TL_SRAM_BURST_EN
            BURST: if (dHs && beatsLeft == '0) stateNext = IDLE;
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && legal && isPut && !a_corrupt) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (a_mask[i]) mem[wordIdx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_opcode  <= '0;
            d_size    <= '0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_corrupt <= 1'b0;
            d_data    <= '0;
`ifdef TL_SRAM_BURST_EN
            curIdx    <= '0;
            beatsLeft <= '0;
`endif
        end else if (accept) begin
            d_opcode  <= isGet ? 3'd1 : 3'd0;
            d_size    <= a_size;
            d_source  <= a_source;
            d_denied  <= !legal;
            d_corrupt <= isGet && !legal;
            d_data    <= (isGet && legal) ? mem[wordIdx] : '0;
`ifdef TL_SRAM_BURST_EN
            curIdx    <= wordIdx;
            beatsLeft <= goBurst ? ((a_size == 4'd4) ? 2'd3 : 2'd1) : 2'd0;
        end else if (state == BURST && dHs && beatsLeft != '0) begin
            // Next beat's word is read on the handshake edge so it is valid the following cycle.
            curIdx    <= nextIdx;
            d_data    <= mem[nextIdx];
            beatsLeft <= beatsLeft - 2'd1;
`endif
        end
    end

endmodule

// File: tb/tb_tl_sram_slave.sv
// Bench for tl_sram_slave: spec-level response model checked every cycle plus literal checks.
module tb_tl_sram_slave;

    localparam logic [31:0] BASE = 32'h80000000;
    localparam int unsigned WORDS = 4096;

    logic        clk = 0;
    logic        rst, a_valid, a_ready, a_corrupt, d_valid, d_ready, d_denied, d_corrupt;
    logic [2:0]  a_opcode, a_param, d_opcode;
    logic [3:0]  a_size, a_mask, d_size;
    logic [4:0]  a_source, d_source;
    logic [31:0] a_address, a_data, d_data;
    logic [1:0]  d_param, d_sink;

    tl_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(WORDS), .AW(12)) dut (
        .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_param(a_param), .a_size(a_size), .a_source(a_source), .a_address(a_address),
        .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt), .d_valid(d_valid),
        .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
        .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_corrupt(d_corrupt),
        .d_data(d_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  sz;
        logic [4:0]  src;
        logic        den;
        logic        cor;
        logic [31:0] data;
    } beatT;

    beatT        expQ[$];
    logic [31:0] seen[$];
    logic [31:0] mdl [WORDS];
    int          errors = 0, checks = 0;
    bit          started = 0, zeroExp = 1;
    logic [2:0]  lastOp;
    logic [4:0]  lastSrc;
    logic        lastDen, lastCor;
    logic [31:0] lastData;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected response beats derived directly from the protocol rules.
    function automatic void modelAccept();
        longint unsigned addr = longint'(a_address);
        bit   isGet = (a_opcode == 3'd4);
        bit   okOp  = isGet || a_opcode == 3'd0 || a_opcode == 3'd1;
        bit   okRange = addr >= longint'(BASE) && addr < longint'(BASE) + 4 * WORDS;
        bit   okAlign = (addr % (longint'(1) << a_size)) == 0;
        bit   okSize  = a_size <= 2;
        bit   legal;
        int   beats = 1;
        int   idx = 0;
        beatT b;
`ifdef TL_SRAM_BURST_EN
        if (isGet && (a_size == 3 || a_size == 4)) okSize = 1;
`endif
        legal = okOp && okRange && okAlign && okSize;
        if (okRange) idx = int'((addr - longint'(BASE)) / 4);
        if (legal && isGet && a_size > 2) beats = (1 << a_size) / 4;
        for (int k = 0; k < beats; k++) begin
            b.op   = isGet ? 3'd1 : 3'd0;
            b.sz   = a_size;
            b.src  = a_source;
            b.den  = !legal;
            b.cor  = isGet && !legal;
            b.data = (isGet && legal) ? mdl[idx + k] : 32'd0;
            expQ.push_back(b);
        end
        if (legal && !isGet && !a_corrupt)
            for (int i = 0; i < 4; i++)
                if (a_mask[i]) mdl[idx][8*i +: 8] = a_data[8*i +: 8];
    endfunction

    always @(negedge clk) begin
        if (started) begin
            logic expReady;
            beatT b;
            expReady = !rst && expQ.size() == 0;
            chk("a_ready", a_ready, expReady);
            if (expQ.size() == 0) begin
                chk("d_valid_idle", d_valid, 0);
                if (zeroExp)
                    chk("d_zero", {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data, d_param, d_sink}, 0);
            end else begin
                b = expQ[0];
                chk("d_valid", d_valid, 1);
                chk("d_opcode", d_opcode, b.op);
                chk("d_size", d_size, b.sz);
                chk("d_source", d_source, b.src);
                chk("d_denied", d_denied, b.den);
                chk("d_corrupt", d_corrupt, b.cor);
                chk("d_data", d_data, b.data);
                chk("d_param_sink", {d_param, d_sink}, 0);
                if (d_ready) begin
                    seen.push_back(d_data);
                    lastOp = d_opcode; lastSrc = d_source; lastDen = d_denied;
                    lastCor = d_corrupt; lastData = d_data;
                    void'(expQ.pop_front());
                end
            end
            if (rst) begin
                expQ.delete();
                zeroExp = 1;
            end else if (a_valid && a_ready) begin
                modelAccept();
                zeroExp = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic corr,
                         input logic [4:0] src, input logic rdy);
        bit got = 0;
        a_opcode = op; a_size = sz; a_address = addr; a_mask = mask; a_data = data;
        a_corrupt = corr; a_source = src; a_param = 3'd5; d_ready = rdy; a_valid = 1;
        seen.delete();
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = a_ready;
            @(posedge clk);
            #1;
        end
        a_valid = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no a_ready expected accept for addr %h", addr);
        end
    endtask

    task automatic finishResp(input int stall);
        bit busy = 1;
        repeat (stall) @(posedge clk);
        #1 d_ready = 1;
        for (int i = 0; i < 40 && busy; i++) begin
            @(posedge clk);
            busy = expQ.size() != 0;
        end
        #1;
        if (busy) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got %0d beats pending expected 0", expQ.size());
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic corr,
                       input logic [4:0] src, input int stall);
        issue(op, sz, addr, mask, data, corr, src, stall == 0);
        finishResp(stall);
    endtask

    initial begin
        rst = 1; a_valid = 0; d_ready = 0; a_opcode = 0; a_param = 0; a_size = 0;
        a_source = 0; a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0;
        repeat (2) @(posedge clk);
        #1 started = 1;
        @(posedge clk);
        #1 rst = 0;

        req(3'd0, 4'd2, 32'h80000010, 4'hF, 32'hDEADBEEF, 0, 5'd3, 0);
        chk("put_op", lastOp, 0);
        chk("put_den", lastDen, 0);
        req(3'd4, 4'd2, 32'h80000010, 4'hF, 32'h0, 0, 5'd7, 0);
        chk("get_data", lastData, 32'hDEADBEEF);
        chk("get_src", lastSrc, 5'd7);
        chk("get_op", lastOp, 1);

        req(3'd1, 4'd2, 32'h80000010, 4'b0010, 32'h0000AA00, 0, 5'd1, 0);
        req(3'd4, 4'd2, 32'h80000010, 4'hF, 32'h0, 0, 5'd2, 0);
        chk("partial_data", lastData, 32'hDEADAAEF);

        req(3'd4, 4'd2, 32'h80004000, 4'hF, 32'h0, 0, 5'd4, 0);
        chk("oor_den_cor_data", {lastDen, lastCor, lastData}, {1'b1, 1'b1, 32'h0});
        req(3'd4, 4'd2, 32'h80000002, 4'hF, 32'h0, 0, 5'd5, 0);
        chk("misalign_den", lastDen, 1);
        req(3'd0, 4'd2, 32'h7FFFFFFC, 4'hF, 32'h11111111, 0, 5'd6, 0);
        chk("put_oor", {lastOp, lastDen, lastCor}, {3'd0, 1'b1, 1'b0});

        req(3'd0, 4'd2, 32'h80000010, 4'hF, 32'h12345678, 1, 5'd8, 0);
        chk("corrupt_put_ack", {lastOp, lastDen}, {3'd0, 1'b0});
        req(3'd4, 4'd1, 32'h80000012, 4'hF, 32'h0, 0, 5'd9, 0);
        chk("corrupt_suppressed", lastData, 32'hDEADAAEF);

        req(3'd0, 4'd2, 32'h80003FFC, 4'hF, 32'hCAFEF00D, 0, 5'd10, 0);
        req(3'd4, 4'd0, 32'h80003FFF, 4'hF, 32'h0, 0, 5'd11, 0);
        chk("last_word", {lastDen, lastData}, {1'b0, 32'hCAFEF00D});

        req(3'd4, 4'd2, 32'h80000010, 4'hF, 32'h0, 0, 5'd12, 5);
        chk("stall_data", lastData, 32'hDEADAAEF);

        issue(3'd4, 4'd2, 32'h80003FFC, 4'hF, 32'h0, 0, 5'd13, 0);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_drop", d_valid, 0);
        @(posedge clk);
        #1 d_ready = 1;
        req(3'd4, 4'd2, 32'h80000010, 4'hF, 32'h0, 0, 5'd14, 0);
        chk("after_rst_data", lastData, 32'hDEADAAEF);

        for (int w = 0; w < 4; w++)
            req(3'd0, 4'd2, 32'h80000020 + 32'(4 * w), 4'hF, 32'(w + 1), 0, 5'd15, 0);
        req(3'd4, 4'd4, 32'h80000020, 4'hF, 32'h0, 0, 5'd16, 2);
`ifdef TL_SRAM_BURST_EN
        chk("burst4_beats", seen.size(), 4);
        for (int k = 0; k < 4 && k < seen.size(); k++) chk("burst4_data", seen[k], 32'(k + 1));
`else
        chk("burst4_beats", seen.size(), 1);
        chk("burst4_denied", {lastDen, lastCor}, 2'b11);
`endif
        req(3'd4, 4'd3, 32'h80000028, 4'hF, 32'h0, 0, 5'd17, 0);
`ifdef TL_SRAM_BURST_EN
        chk("burst2_beats", seen.size(), 2);
        chk("burst2_last", lastData, 32'd4);
`else
        chk("burst2_beats", seen.size(), 1);
        chk("burst2_denied", lastDen, 1);
`endif
        req(3'd0, 4'd3, 32'h80000020, 4'hF, 32'h0, 0, 5'd18, 0);
        chk("put_size3_denied", lastDen, 1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
